// File: rtl/reg_mux_nx1.sv
// reg_mux_nx1: registered N:1 channel selector with valid/ready handshakes.
//
// Picks one WIDTH-bit channel of in_data per accepted transfer, registers it
// and presents it on out_data until the downstream takes it. An out-of-range
// select captures zeros and raises the sticky sel_err flag.
//
// Build option (macro REG_MUX_SKID_EN):
//   defined     - main register plus one-entry skid register; in_ready is a
//                 pure register output (~skid_full), two words of storage.
//   not defined - main register only; in_ready = ~out_valid | out_ready
//                 (combinational from out_ready), one word of storage.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   upstream has a transfer
//   in_ready   block can accept this cycle
//   sel        channel index, sampled on accept
//   in_data    N channels, channel k at [k*WIDTH +: WIDTH]
//   out_valid  out_data holds a transfer
//   out_ready  downstream accepts
//   out_data   selected, registered data
//   sel_err    sticky: an accepted sel was >= N
//   xfer_cnt   completed output transfers, wraps modulo 256
module reg_mux_nx1 #(
    parameter int unsigned  WIDTH = 5,
    parameter int unsigned  N     = 4,
    localparam int unsigned SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               sel_err,
    output logic [7:0]         xfer_cnt
);

    logic             accept;
    logic             drain;
    logic             sel_ok;
    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] cap_word;

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             sel_err_q, sel_err_d;
    logic [7:0]       xfer_cnt_q, xfer_cnt_d;

    assign accept = in_valid & in_ready;
    assign drain  = m_valid_q & out_ready;

    // Non-power-of-two N leaves sel codes with no channel behind them.
    assign sel_ok = 32'(sel) < N;

    always_comb begin
        sel_word = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign cap_word = sel_ok ? sel_word : '0;

`ifdef REG_MUX_SKID_EN
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q,  s_data_d;

    // Registered ready: only a full skid entry can block the input.
    assign in_ready = ~s_valid_q;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (drain) begin
            if (s_valid_q) begin
                // in_ready is low here, so no accept can collide with the refill.
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_data_d = cap_word;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = cap_word;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = cap_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end
`else
    // Single-entry stage: a draining word frees the register in the same cycle.
    assign in_ready = ~m_valid_q | out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = cap_word;
        end else if (drain) begin
            m_valid_d = 1'b0;
        end
    end
`endif

    assign sel_err_d  = sel_err_q | (accept & ~sel_ok);
    assign xfer_cnt_d = drain ? xfer_cnt_q + 8'd1 : xfer_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            sel_err_q  <= 1'b0;
            xfer_cnt_q <= 8'd0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            sel_err_q  <= sel_err_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign sel_err   = sel_err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule
